uart_tx: RTL and testbench



---
 rtl/uart_tx_if.sv | 21 ++
 rtl/uart_tx.sv | 97 +++++++++
 tb/tb_uart_tx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte-request / serial-line bundle between a UART transmit client and uart_tx.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_type;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data, data_valid, par_en, par_type,
    input  tx_out, busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_type,
    output tx_out, busy
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_WIDTH bits LSB first, optional parity, stop; one bit per clk.
// Start bit appears the edge a request is accepted; requests while busy are dropped, not queued.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]            r_state;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_shadow;
  logic                  r_par_en;
  logic                  r_par_type;
  logic                  r_tx_out;
  logic                  r_busy;

  logic [CW-1:0]         w_cnt_nxt;
  logic                  w_last;
  logic                  w_parity;

  assign w_cnt_nxt = r_cnt + CW'(1);
  assign w_last    = (r_cnt == CW'(DATA_WIDTH - 1));
  assign w_parity  = (^r_shadow) ^ r_par_type;

  assign bus.tx_out = r_tx_out;
  assign bus.busy   = r_busy;

  // tx_out is loaded with the bit for the state being entered, so the line is fully registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shadow   <= '0;
      r_par_en   <= 1'b0;
      r_par_type <= 1'b0;
      r_tx_out   <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx_out <= 1'b1;
          r_busy   <= 1'b0;
          if (bus.data_valid) begin
            r_shadow   <= bus.p_data;
            r_par_en   <= bus.par_en;
            r_par_type <= bus.par_type;
            r_cnt      <= '0;
            r_tx_out   <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
          r_tx_out <= r_shadow[0];
          r_state  <= S_DATA;
        end
        S_DATA: begin
          if (w_last) begin
            if (r_par_en) begin
              r_tx_out <= w_parity;
              r_state  <= S_PARITY;
            end else begin
              r_tx_out <= 1'b1;
              r_state  <= S_STOP;
            end
          end else begin
            r_cnt    <= w_cnt_nxt;
            r_tx_out <= r_shadow[w_cnt_nxt];
          end
        end
        S_PARITY: begin
          r_tx_out <= 1'b1;
          r_state  <= S_STOP;
        end
        S_STOP: begin
          r_tx_out <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_tx_out <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: line and busy are sampled 1 time unit after each rising edge.
module tb_uart_tx;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] txs;
  logic [31:0] bs;

  uart_tx_if #(.DATA_WIDTH(8)) bus ();

  uart_tx #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sample 16 cycles starting with the acceptance edge; index 0 holds the start bit.
  task automatic capture_frame(input logic [7:0] d, input logic pen, input logic pt);
    bus.p_data     = d;
    bus.par_en     = pen;
    bus.par_type   = pt;
    bus.data_valid = 1'b1;
    txs = '1;
    bs  = '0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      txs[i] = bus.tx_out;
      bs[i]  = bus.busy;
      if (i == 0) bus.data_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.tx_out !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", bus.tx_out); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_cycle_%0d: got tx=%b busy=%b expected tx=1 busy=0", i, bus.tx_out, bus.busy);
      end
    end
  endtask

  task automatic test_no_parity();
    capture_frame(8'hA5, 1'b0, 1'b0);
    checks++;
    if (txs[15:0] !== {7'h7F, 8'hA5, 1'b0}) begin
      errors++; $display("FAIL a5_noparity_line: got %h expected %h", txs[15:0], {7'h7F, 8'hA5, 1'b0});
    end
    checks++;
    if (bs[15:0] !== 16'h03FF) begin
      errors++; $display("FAIL a5_noparity_busy: got %h expected 03ff", bs[15:0]);
    end
  endtask

  task automatic test_parity();
    // 0xA5 has four ones: even parity bit 0
    capture_frame(8'hA5, 1'b1, 1'b0);
    checks++;
    if (txs[15:0] !== {5'h1F, 1'b1, 1'b0, 8'hA5, 1'b0}) begin
      errors++; $display("FAIL a5_even_line: got %h expected %h", txs[15:0], {5'h1F, 1'b1, 1'b0, 8'hA5, 1'b0});
    end
    checks++;
    if (bs[15:0] !== 16'h07FF) begin
      errors++; $display("FAIL a5_even_busy: got %h expected 07ff", bs[15:0]);
    end
    capture_frame(8'hA5, 1'b1, 1'b1);
    checks++;
    if (txs[15:0] !== {5'h1F, 1'b1, 1'b1, 8'hA5, 1'b0}) begin
      errors++; $display("FAIL a5_odd_line: got %h expected %h", txs[15:0], {5'h1F, 1'b1, 1'b1, 8'hA5, 1'b0});
    end
    checks++;
    if (bs[15:0] !== 16'h07FF) begin
      errors++; $display("FAIL a5_odd_busy: got %h expected 07ff", bs[15:0]);
    end
    capture_frame(8'h01, 1'b1, 1'b1);
    checks++;
    if (txs[9] !== 1'b0) begin
      errors++; $display("FAIL 01_odd_parity_bit: got %b expected 0", txs[9]);
    end
    checks++;
    if (txs[15:0] !== {5'h1F, 1'b1, 1'b0, 8'h01, 1'b0}) begin
      errors++; $display("FAIL 01_odd_line: got %h expected %h", txs[15:0], {5'h1F, 1'b1, 1'b0, 8'h01, 1'b0});
    end
  endtask

  task automatic test_drop_while_busy();
    bus.p_data = 8'hA5; bus.par_en = 1'b0; bus.par_type = 1'b0; bus.data_valid = 1'b1;
    txs = '1; bs = '0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      txs[i] = bus.tx_out;
      bs[i]  = bus.busy;
      if (i == 0) begin
        bus.data_valid = 1'b0; bus.p_data = 8'hFF; bus.par_en = 1'b1; bus.par_type = 1'b1;
      end
      if (i == 3) begin bus.data_valid = 1'b1; bus.p_data = 8'h3C; end
      if (i == 4) bus.data_valid = 1'b0;
    end
    bus.par_en = 1'b0; bus.par_type = 1'b0;
    checks++;
    if (txs[23:0] !== {8'hFF, 7'h7F, 8'hA5, 1'b0}) begin
      errors++; $display("FAIL drop_line: got %h expected %h", txs[23:0], {8'hFF, 7'h7F, 8'hA5, 1'b0});
    end
    checks++;
    if (bs[23:0] !== 24'h0003FF) begin
      errors++; $display("FAIL drop_busy: got %h expected 0003ff", bs[23:0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    bus.p_data = 8'hA5; bus.par_en = 1'b0; bus.data_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 0) bus.data_valid = 1'b0;
    end
    // cycle 4 carries data bit 3 of 0xA5, which is 0
    checks++;
    if (bus.tx_out !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL mid_bit3: got tx=%b busy=%b expected tx=0 busy=1", bus.tx_out, bus.busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got tx=%b busy=%b expected tx=1 busy=0", bus.tx_out, bus.busy);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got tx=%b busy=%b expected tx=1 busy=0", bus.tx_out, bus.busy);
    end
    capture_frame(8'h5A, 1'b0, 1'b0);
    checks++;
    if (txs[15:0] !== {7'h7F, 8'h5A, 1'b0}) begin
      errors++; $display("FAIL post_reset_5a_line: got %h expected %h", txs[15:0], {7'h7F, 8'h5A, 1'b0});
    end
    checks++;
    if (bs[15:0] !== 16'h03FF) begin
      errors++; $display("FAIL post_reset_5a_busy: got %h expected 03ff", bs[15:0]);
    end
  endtask

  task automatic test_reset_wins();
    rst = 1'b1; bus.data_valid = 1'b1; bus.p_data = 8'hC3;
    @(posedge clk); #1;
    checks++;
    if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rst_vs_valid: got tx=%b busy=%b expected tx=1 busy=0", bus.tx_out, bus.busy);
    end
    rst = 1'b0; bus.data_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rst_vs_valid_after: got tx=%b busy=%b expected tx=1 busy=0", bus.tx_out, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    bus.p_data = 8'hA5; bus.par_en = 1'b0; bus.par_type = 1'b0; bus.data_valid = 1'b1;
    txs = '1; bs = '0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      txs[i] = bus.tx_out;
      bs[i]  = bus.busy;
      if (i == 0) bus.p_data = 8'h3C;
      if (i == 11) bus.data_valid = 1'b0;
    end
    // second start must follow exactly one idle cycle after the first stop bit
    checks++;
    if (txs[23:0] !== {3'b111, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}) begin
      errors++;
      $display("FAIL b2b_line: got %h expected %h", txs[23:0], {3'b111, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0});
    end
    checks++;
    if (bs[23:0] !== {3'b000, 10'h3FF, 1'b0, 10'h3FF}) begin
      errors++; $display("FAIL b2b_busy: got %h expected %h", bs[23:0], {3'b000, 10'h3FF, 1'b0, 10'h3FF});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.p_data = 8'h00;
    bus.data_valid = 1'b0;
    bus.par_en = 1'b0;
    bus.par_type = 1'b0;
    test_reset();
    test_no_parity();
    test_parity();
    test_drop_while_busy();
    test_reset_mid_frame();
    test_reset_wins();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
